// File: rtl/maze_pkg.sv
// Shared maze types and sizes, used by the memory arbiter, the solver and the loader.
package maze_pkg;

    localparam int MAZE_ADDR_W = 8;
    localparam int MAZE_DATA_W = 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_H    = 2'd1,
        OWN_S    = 2'd2
    } ownerT;

endpackage

// File: rtl/maze_rr_pick2.sv
// Two-way round-robin picker; last=1 means the solver was granted most recently.
module maze_rr_pick2 (
    input  logic elig_h,
    input  logic elig_s,
    input  logic last,
    output logic pick_h,
    output logic pick_s
);

    assign pick_h = elig_h & (~elig_s | last);
    assign pick_s = elig_s & (~elig_h | ~last);

endmodule

// File: rtl/maze_mem_arbiter.sv
// Shares the single-port maze memory between the host loader and the solver.
// state    | meaning
// OWN_NONE | no memory access this cycle
// OWN_H    | host command drives the memory, h_gnt high
// OWN_S    | solver command drives the memory, s_gnt high
module maze_mem_arbiter
    import maze_pkg::*;
#(
    parameter int ADDR_W  = MAZE_ADDR_W,
    parameter int DATA_W  = MAZE_DATA_W,
    parameter int STALL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               h_req,
    input  logic               h_lock,
    input  logic               h_we,
    input  logic [ADDR_W-1:0]  h_addr,
    input  logic [DATA_W-1:0]  h_wdata,
    output logic               h_gnt,
    output logic               h_rvalid,
    output logic [DATA_W-1:0]  h_rdata,
    input  logic               s_req,
    input  logic               s_we,
    input  logic [ADDR_W-1:0]  s_addr,
    input  logic [DATA_W-1:0]  s_wdata,
    output logic               s_gnt,
    output logic               s_rvalid,
    output logic [DATA_W-1:0]  s_rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               locked,
    output logic [STALL_W-1:0] s_stall_cnt
);

    ownerT              state;
    logic               lastS;
    logic               lockedR;
    logic               hGnt;
    logic               sGnt;
    logic               hRv;
    logic               sRv;
    logic [STALL_W-1:0] stallCnt;

    logic lockCur;
    logic eligH;
    logic eligS;
    logic pickH;
    logic pickS;

    // A lock only survives a decision while the host keeps h_lock high.
    always_comb begin
        lockCur = lockedR & h_lock;
        eligH   = h_req & ~((state == OWN_H) & ~lockCur);
        eligS   = s_req & ~lockCur & (state != OWN_S);
    end

    maze_rr_pick2 u_pick (
        .elig_h (eligH),
        .elig_s (eligS),
        .last   (lastS),
        .pick_h (pickH),
        .pick_s (pickS)
    );

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (hGnt) begin
            mem_we    = h_we;
            mem_addr  = h_addr;
            mem_wdata = h_wdata;
        end else if (sGnt) begin
            mem_we    = s_we;
            mem_addr  = s_addr;
            mem_wdata = s_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OWN_NONE;
            lastS    <= 1'b1;
            lockedR  <= 1'b0;
            hGnt     <= 1'b0;
            sGnt     <= 1'b0;
            hRv      <= 1'b0;
            sRv      <= 1'b0;
            stallCnt <= '0;
        end else begin
            hGnt    <= pickH;
            sGnt    <= pickS;
            state   <= pickH ? OWN_H : (pickS ? OWN_S : OWN_NONE);
            lockedR <= (pickH & h_lock) | lockCur;
            if (pickH | pickS)
                lastS <= pickS;
            hRv <= hGnt & ~mem_we;
            sRv <= sGnt & ~mem_we;
            if (s_req & ~sGnt & ~(&stallCnt))
                stallCnt <= stallCnt + {{(STALL_W-1){1'b0}}, 1'b1};
        end
    end

    assign h_gnt       = hGnt;
    assign s_gnt       = sGnt;
    assign mem_en      = hGnt | sGnt;
    assign h_rvalid    = hRv;
    assign s_rvalid    = sRv;
    assign h_rdata     = mem_rdata;
    assign s_rdata     = mem_rdata;
    assign locked      = lockedR;
    assign s_stall_cnt = stallCnt;

endmodule
